fp8_expander: RTL
=================

Name: fp8_expander

Overview:
- Downstream stage of the 12-bit-linear to 8-bit floating-point converter.
- Consumes the 8-bit float {S, E[2:0], F[3:0]}, where V = (-1)^S * F * 2^E, and reconstructs the 12-bit two's-complement linear value.
- Uses a sequential shift-per-cycle datapath with valid/ready handshakes on both sides.
- Used for round-trip checking and for feeding linear consumers (display, DAC path) from compressed samples.

Parameters:
- EXP_W, 3, exponent field width.
- MAN_W, 4, significand field width.
- OUT_W, 12, output width. Must satisfy OUT_W >= MAN_W + 2^EXP_W; the defaults meet this exactly.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  upstream presents in_fp.
- in_ready  out  1  block can accept a new float.
- in_fp  in  1+EXP_W+MAN_W (8)  packed float {S, E, F}.
- out_valid  out  1  out_val holds a finished result.
- out_ready  in  1  downstream accepts out_val.
- out_val  out  OUT_W (12)  two's-complement linear value.
- out_negzero  out  1  input was S=1 with F=0; out_val is 0 in this case.

Behaviour:
- Reset (async assert; release is sampled on the next clk edge):
  - state=IDLE, in_ready=1, out_valid=0, out_val=0, out_negzero=0.
  - Internal acc=0, cnt=0, sign=0.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - Capture sign=S, acc={zeros,F} as an unsigned OUT_W-bit magnitude, cnt=E.
  - If E==0, go to DONE; otherwise go to SHIFT.
- SHIFT: each cycle acc<=acc<<1 and cnt<=cnt-1. When cnt==1 (the last shift), go to DONE.
  - in_ready=0 and out_valid=0 throughout SHIFT.
- DONE entry: out_val <= sign ? (~acc+1) : acc; out_negzero <= sign && (acc==0); out_valid=1.
- DONE holds out_val and out_negzero stable until out_ready.
- In DONE, in_ready=out_ready, so a new input can be accepted in the same cycle the result is popped:
  - If in_valid&&out_ready: pop and capture the new input simultaneously; next state is SHIFT, or DONE if the new E==0.
  - If out_ready only: go to IDLE and drop out_valid.
- Latency: E+1 cycles from the accepting edge to out_valid=1.
  - Back-to-back throughput is one result per E+1 cycles when out_ready is held high.
- Arithmetic:
  - Magnitude is at most 15*2^7 = 1920, so no overflow for the defaults.
  - Negation is 12-bit two's complement; -1920 is 12'h880.
  - No saturation logic is required.
- in_fp is ignored whenever in_ready=0; no input buffering.
- Changes to in_valid or in_fp while in SHIFT have no effect.
- Async rst asserted mid-operation (SHIFT or DONE): immediate return to reset values. The in-flight value is discarded and never appears on out_val.
- out_val and out_negzero change only on DONE entry; their values outside DONE are don't-care for checking and are held at the last result.

Decomposition:
- Shared package fpcvt_pkg holds:
  - EXP_W, MAN_W, OUT_W constants.
  - The packed float typedef fp8_t {logic s; logic [2:0] e; logic [3:0] f;}.
  - The state enum {IDLE, SHIFT, DONE}.
- The same package is reused by the upstream converter and its bench.
- No sub-module is needed; the negation is a single expression. Optional: a fp8_expander_ref function in the package as the bench's golden model, out = (-1)^S*F<<E.

Test Plan:
- in_fp=8'h5D (S0,E5,F13), out_ready=1 -> out_valid exactly 6 cycles after accept, out_val=12'h1A0 (416), out_negzero=0.
- in_fp=8'hDD -> out_val=12'hE60 (-416). Then in_fp=8'h2E -> out_val=12'h038 (56) after 3 cycles.
- Extremes: 8'h7F -> 12'h780 (1920); 8'hFF -> 12'h880 (-1920); 8'h00 -> 0 with 1-cycle latency; 8'h80 -> out_val=0, out_negzero=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: out_val stays stable, in_ready=0.
  - Raise out_ready with in_valid=1 and in_fp=8'h10 (E1,F0): same-cycle pop and accept; the next result, 0, appears 2 cycles later.
- Assert rst during SHIFT of 8'h7F: out_valid=0 and in_ready=1 immediately. After release, 8'h13 -> 12'h006 (E1,F3 -> 6) with no residue from the aborted value.
- Random sweep of all 256 in_fp codes with random out_ready stalls: every out_val matches the golden model, no result is lost or duplicated, and results come out in order.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared definitions for the 12-bit linear <-> 8-bit float converter pair.
// The upstream converter, this expander and their benches all use this package.
package fpcvt_pkg;

  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam int OUT_W = 12;

  typedef struct packed {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
  } fp8_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp8_expander.sv
// Expands {S, E, F} floats back to OUT_W-bit two's-complement linear values,
// shifting the significand left one bit per clock.
module fp8_expander #(
  parameter int EXP_W = fpcvt_pkg::EXP_W,
  parameter int MAN_W = fpcvt_pkg::MAN_W,
  parameter int OUT_W = fpcvt_pkg::OUT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_fp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_val,
  output logic                   out_negzero
);
  import fpcvt_pkg::*;

  state_t            r_state;
  logic [OUT_W-1:0]  r_acc;
  logic [EXP_W-1:0]  r_cnt;
  logic              r_sign;
  logic [OUT_W-1:0]  r_out_val;
  logic              r_negzero;

  logic              w_s;
  logic [EXP_W-1:0]  w_e;
  logic [MAN_W-1:0]  w_f;
  logic [OUT_W-1:0]  w_f_ext;
  logic [OUT_W-1:0]  w_acc_shl;
  logic              w_take;

  assign w_s       = in_fp[EXP_W+MAN_W];
  assign w_e       = in_fp[MAN_W +: EXP_W];
  assign w_f       = in_fp[MAN_W-1:0];
  assign w_f_ext   = {{(OUT_W-MAN_W){1'b0}}, w_f};
  assign w_acc_shl = r_acc << 1;

  // DONE forwards out_ready so a pop and a new accept can share one edge.
  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid = (r_state == DONE);
  assign w_take    = in_valid && in_ready;

  assign out_val     = r_out_val;
  assign out_negzero = r_negzero;

  function automatic logic [OUT_W-1:0] apply_sign(input logic s, input logic [OUT_W-1:0] m);
    return s ? (~m + OUT_W'(1)) : m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_out_val <= '0;
      r_negzero <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_take) begin
            r_sign <= w_s;
            r_acc  <= w_f_ext;
            r_cnt  <= w_e;
            if (w_e == '0) begin
              r_state   <= DONE;
              r_out_val <= apply_sign(w_s, w_f_ext);
              r_negzero <= w_s && (w_f == '0);
            end else begin
              r_state <= SHIFT;
            end
          end else if ((r_state == DONE) && out_ready) begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_acc <= w_acc_shl;
          r_cnt <= r_cnt - EXP_W'(1);
          // Result is formed from the post-shift magnitude on the final shift.
          if (r_cnt == EXP_W'(1)) begin
            r_state   <= DONE;
            r_out_val <= apply_sign(r_sign, w_acc_shl);
            r_negzero <= r_sign && (w_acc_shl == '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
